// File: rtl/mips_defs.sv
// Shared definitions for the 5-stage MIPS pipeline: register specifier width,
// ALU op encoding and default datapath width.
package mips_defs;

  localparam int REG_W      = 5;
  localparam int ALU_OP_W   = 4;
  localparam int DATA_W_DEF = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd12;

  // True when a write to dst is visible to a read of src; $zero never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID. A flushed ID instruction never stalls.
module hazard_detect
  import mips_defs::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             hz,
  output logic             stall
);

  assign hz    = ex_valid & ex_mem_read & (reg_hit(ex_rd, id_rs) | reg_hit(ex_rd, id_rt));
  assign stall = hz & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Optional saturating stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
  import mips_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  output logic                stall,
`ifdef ID_EX_STALL_CNT_EN
  output logic [CNT_W-1:0]    stall_count,
`endif
  output logic                ex_valid,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op
);

  logic hz;
  logic bubble;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .hz          (hz),
    .stall       (stall)
  );

  // A flush bubbles regardless of the hazard; otherwise a hazard bubbles.
  assign bubble = hz | flush;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_rs         <= REG_ZERO;
      ex_rt         <= REG_ZERO;
      ex_rd         <= REG_ZERO;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bubble) begin
      // Data fields keep stale values; zero specifiers stop forwarding matches.
      ex_valid      <= 1'b0;
      ex_rs         <= REG_ZERO;
      ex_rt         <= REG_ZERO;
      ex_rd         <= REG_ZERO;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_alu_op     <= id_alu_op;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a behavioural model of the
// ID/EX register; the counter checks run when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_stage;

  localparam int DW = 32;

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic        id_mem_to_reg = 1'b0, id_alu_src = 1'b0;
  logic [3:0]  id_alu_op = '0;

  logic        stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_alu_op;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_count;
  logic        s_stall, s_valid;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_rs_data, s_rt_data, s_imm;
  logic        s_rw, s_mr, s_mw, s_m2r, s_as;
  logic [3:0]  s_op;
  logic [1:0]  s_count;
`endif

  ex_t m;
  int  stall_total;
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .stall(stall),
`ifdef ID_EX_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
  );

`ifdef ID_EX_STALL_CNT_EN
  id_ex_stage #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .stall(s_stall), .stall_count(s_count),
    .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
    .ex_reg_write(s_rw), .ex_mem_read(s_mr), .ex_mem_write(s_mw),
    .ex_mem_to_reg(s_m2r), .ex_alu_src(s_as), .ex_alu_op(s_op)
  );
`endif

  // ---------------- reference model ----------------
  function automatic logic model_stall();
    logic hz;
    hz = m.valid && m.mr && (m.rd != 5'd0) && ((m.rd == id_rs) || (m.rd == id_rt));
    return hz && !flush;
  endfunction

  function automatic logic model_bubble();
    return model_stall() || flush;
  endfunction

  task automatic model_reset();
    m = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rs_data: '0, rt_data: '0, imm: '0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, as: 1'b0, op: '0};
    stall_total = 0;
  endtask

  function automatic int exp_count(input int cap);
    return (stall_total > cap) ? cap : stall_total;
  endfunction

  // Data fields only matter when EX holds a real instruction.
  function automatic logic [120:0] pack_dut();
    return {ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
            ex_mem_to_reg, ex_alu_src, ex_alu_op,
            ex_valid ? {ex_rs_data, ex_rt_data, ex_imm} : 96'd0};
  endfunction

  function automatic logic [120:0] pack_model();
    return {m.valid, m.rs, m.rt, m.rd, m.rw, m.mr, m.mw, m.m2r, m.as, m.op,
            m.valid ? {m.rs_data, m.rt_data, m.imm} : 96'd0};
  endfunction

  // Advance one clock edge, applying the model's update rule in parallel.
  task automatic clock_edge();
    logic s, b;
    s = model_stall();
    b = model_bubble();
    @(posedge clk);
    if (s) stall_total++;
    if (b) begin
      m.valid = 1'b0; m.rs = '0; m.rt = '0; m.rd = '0;
      m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.m2r = 1'b0; m.as = 1'b0; m.op = '0;
    end else begin
      m.valid = 1'b1; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
      m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
      m.m2r = id_mem_to_reg; m.as = id_alu_src; m.op = id_alu_op;
    end
    #1;
  endtask

  task automatic rand_id(input int max_reg);
    @(negedge clk);
    id_rs = 5'($urandom_range(max_reg, 0));
    id_rt = 5'($urandom_range(max_reg, 0));
    id_rd = 5'($urandom_range(max_reg, 0));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    id_alu_src = 1'($urandom); id_alu_op = 4'($urandom);
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) begin
      rand_id(31);
      clock_edge();
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (pack_dut() !== 121'd0 || ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0 || ex_imm !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ex: got %h required 0", pack_dut());
    end
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b required 0", stall);
    end
`ifdef ID_EX_STALL_CNT_EN
    n_tests++;
    if (stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", stall_count);
    end
`endif
    #1 rst = 1'b0;
  endtask

  task automatic test_plain_advance();
    @(negedge clk);
    flush = 1'b0;
    id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd5;
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'h33;
    id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_alu_op = 4'd2;
    clock_edge();
    n_tests++;
    if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_reg_write} !==
        {1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 1'b1}) begin
      n_fail++;
      $display("FAIL plain_advance: got v=%b rs=%0d rt=%0d rd=%0d d=%h rw=%b required v=1 rs=3 rt=4 rd=5 d=11 rw=1",
               ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_reg_write);
    end
  endtask

  task automatic test_load_use();
    int base;
    base = stall_total;
    @(negedge clk);
    id_rs = 5'd7; id_rt = 5'd8; id_rd = 5'd1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    id_reg_write = 1'b1; id_mem_write = 1'b0; flush = 1'b0;
    clock_edge();
    @(negedge clk);
    id_rs = 5'd1; id_rt = 5'd9; id_rd = 5'd10; id_mem_read = 1'b0; id_mem_to_reg = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b required 1", stall);
    end
    clock_edge();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_rs !== 5'd0 || pack_dut() !== 121'd0) begin
      n_fail++;
      $display("FAIL load_use_bubble: got %h required 0", pack_dut());
    end
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_release: got %b required 0", stall);
    end
`ifdef ID_EX_STALL_CNT_EN
    n_tests++;
    if (int'(stall_count) != base + 1) begin
      n_fail++;
      $display("FAIL load_use_count: got %0d required %0d", stall_count, base + 1);
    end
`endif
    clock_edge();
    n_tests++;
    if (pack_dut() !== pack_model() || ex_rs !== 5'd1) begin
      n_fail++;
      $display("FAIL load_use_advance: got %h required %h", pack_dut(), pack_model());
    end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    id_rs = 5'd6; id_rt = 5'd6; id_rd = 5'd0; id_mem_read = 1'b1; flush = 1'b0;
    clock_edge();
    @(negedge clk);
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd2; id_mem_read = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_zero_stall: got %b required 0", stall);
    end
    clock_edge();
  endtask

  task automatic test_flush_priority();
    @(negedge clk);
    id_rs = 5'd4; id_rt = 5'd4; id_rd = 5'd2; id_mem_read = 1'b1;
    id_reg_write = 1'b1; id_alu_src = 1'b1; id_alu_op = 4'd6; flush = 1'b0;
    clock_edge();
    @(negedge clk);
    id_rs = 5'd2; id_rt = 5'd3; id_rd = 5'd9; id_mem_write = 1'b1; flush = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got %b required 0", stall);
    end
    clock_edge();
    n_tests++;
    if (pack_dut() !== 121'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %h required 0", pack_dut());
    end
    @(negedge clk);
    flush = 1'b0; id_mem_write = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd5; id_mem_read = 1'b1; flush = 1'b0;
    clock_edge();
    @(negedge clk);
    id_rs = 5'd5; id_rt = 5'd3; id_rd = 5'd6; id_mem_read = 1'b0;
    id_rs_data = 32'hCAFE_0001;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stall_pre: got %b required 1", stall);
    end
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (stall !== 1'b0 || ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stall_reset: got stall=%b valid=%b required 0 0", stall, ex_valid);
    end
    #1 rst = 1'b0;
    clock_edge();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd5 || ex_rs_data !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL mid_stall_load: got v=%b rs=%0d d=%h required v=1 rs=5 d=cafe0001",
               ex_valid, ex_rs, ex_rs_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id(3);
      flush = ($urandom_range(7, 0) == 0);
      #1;
      n_tests++;
      if (stall !== model_stall()) begin
        n_fail++;
        $display("FAIL random_stall[%0d]: got %b required %b", i, stall, model_stall());
      end
      clock_edge();
      n_tests++;
      if (pack_dut() !== pack_model()) begin
        n_fail++;
        $display("FAIL random_ex[%0d]: got %h required %h", i, pack_dut(), pack_model());
      end
    end
`ifdef ID_EX_STALL_CNT_EN
    n_tests++;
    if (int'(stall_count) != exp_count(65535)) begin
      n_fail++;
      $display("FAIL random_count: got %0d required %0d", stall_count, exp_count(65535));
    end
`endif
  endtask

  // Back-to-back dependent loads: each stalls exactly once, never locks up.
  task automatic test_back_to_back();
    int base;
    base = stall_total;
    @(negedge clk);
    id_rs = 5'd1; id_rt = 5'd0; id_rd = 5'd1; id_mem_read = 1'b1; flush = 1'b0;
    clock_edge();
    base = stall_total;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (stall !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL b2b_stall[%0d]: got %b required %b", i, stall, (i % 2) == 0);
      end
      clock_edge();
    end
    n_tests++;
    if (stall_total - base != 5 || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_progress: got stalls=%0d valid=%b required 5 1", stall_total - base, ex_valid);
    end
`ifdef ID_EX_STALL_CNT_EN
    n_tests++;
    if (s_count !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_count: got %0d required 3", s_count);
    end
    n_tests++;
    if (int'(stall_count) != exp_count(65535)) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d required %0d", stall_count, exp_count(65535));
    end
`endif
    @(negedge clk);
    id_mem_read = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    test_reset();
    test_plain_advance();
    test_load_use();
    test_reg_zero();
    test_flush_priority();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
